wb_fetch_buffer: RTL and testbench
==================================

Name: wb_fetch_buffer

Overview:
Wishbone classic-burst master that prefetches sequential 32-bit instruction words from the on-chip Wishbone RAM into a small FIFO. The CPU fetch stage consumes words through a valid/ready interface. It sits directly upstream of the RAM slave: it drives the slave's request signals and consumes its data and ack. A redirect input (branch/jump) flushes the buffer and restarts fetching at a new word address.

Parameters:
DEPTH, 8, FIFO entries (power of 2, >= BURST_LEN)
BURST_LEN, 4, beats per incrementing burst (power of 2, >= 2)
RESET_ADR, 30'h0, word address fetched first after reset

Ports:
clk_i  in  1  system clock, all logic on rising edge
rst_i  in  1  synchronous active-high reset
redirect_i  in  1  flush and restart fetch
redirect_adr_i  in  30  new word address, sampled when redirect_i=1
instr_o  out  32  FIFO head word
instr_adr_o  out  30  word address of instr_o
instr_valid_o  out  1  FIFO non-empty
instr_ready_i  in  1  consumer pops when valid&ready
wb_dat_i  in  32  read data from slave
wb_dat_o  out  32  tied 0
wb_adr_o  out  30  word address, bits [31:2]
wb_we_o  out  1  tied 0
wb_sel_o  out  4  tied 4'b1111
wb_cyc_o  out  1  bus cycle
wb_stb_o  out  1  strobe
wb_cti_o  out  3  010 = incrementing burst, 111 = end of burst
wb_ack_i  in  1  slave ack

Behaviour:
- Reset (synchronous, rst_i=1 at clock edge): FSM=IDLE; FIFO empty; fetch_adr=RESET_ADR; wb_cyc_o=wb_stb_o=0; wb_cti_o=000; instr_valid_o=0. rst_i asserted mid-burst drops cyc/stb on the next edge; any ack arriving afterwards is ignored.
- FIFO: DEPTH entries of {adr[29:0], data[31:0]}. Count is $clog2(DEPTH)+1 bits wide. Pointers wrap mod DEPTH. Push and pop in the same cycle leave the count unchanged. Pop on empty is impossible because valid=0.
- Space reservation: a burst may start only when (count + in-flight beats) <= DEPTH - BURST_LEN. This guarantees every acked beat can be pushed with no backpressure onto the bus.
- FSM IDLE: if the space condition holds and there is no redirect, go to BURST next cycle. Set cyc=stb=1, wb_adr_o=fetch_adr, beat=0.
- FSM BURST: wb_cti_o=010 while beat < BURST_LEN-1, and 111 on the final beat. Each cycle with wb_ack_i=1:
  - push {wb_adr_o, wb_dat_i}
  - wb_adr_o += 1 (30-bit wrap 3FFFFFFF -> 0)
  - beat += 1
- On the ack of the final beat (cti=111): cyc=stb=0 next cycle, cti=000, fetch_adr=wb_adr_o+1, go to IDLE. Back-to-back bursts therefore have at least one idle cycle. The slave's registered ack drops after a cti=111 beat.
- Throughput: the slave acks the first beat one cycle after stb, then every cycle. A 4-beat burst takes 5 cycles of cyc.
- Redirect in IDLE: clear FIFO, fetch_adr=redirect_adr_i, stay IDLE.
- Redirect in BURST: clear FIFO, latch fetch_adr=redirect_adr_i, go to DRAIN. Any same-cycle ack data is discarded.
- FSM DRAIN: keep cyc=stb=1 with cti=111 until wb_ack_i=1, discarding data. Then drop cyc/stb and go to IDLE. This gives the slave a legal burst end.
- Redirect in DRAIN: update the latched fetch_adr only.
- Redirect together with a pop: redirect wins, and the FIFO is empty on the next cycle.
- Latency: from redirect in IDLE to first instr_valid_o is 3 cycles (IDLE->BURST, stb, ack/push, visible).
- wb_we_o=0 and wb_sel_o=4'b1111 always. The block never issues single (cti=000) cycles.

Optional Feature:
WB_FETCH_PERF_EN
- Defined: adds output ports perf_words_o[31:0] and perf_flush_o[15:0].
  - perf_words_o counts words popped by the consumer.
  - perf_flush_o counts redirects.
  - Both wrap on overflow, reset to 0, and are readable every cycle.
- Undefined: the ports and counters are absent; no other behaviour changes.

Decomposition:
- Shared package wb_pkg holds:
  - CTI constants: CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_EOB=3'b111.
  - FSM enum fetch_state_t {IDLE, BURST, DRAIN}.
  - Typedef fetch_entry_t {adr[29:0], dat[31:0]}.
- One sub-module, sync_fifo: parameterised width/depth with push/pop/flush, count, empty/full. The top keeps the FSM, address counter and reservation logic.

Test Plan:
- Reset release with RESET_ADR=0 and RAM preloaded mem[i]=i*0x11111111 -> burst adr 0..3, cti 010,010,010,111; consumer always ready sees instr_o 0x0,0x11111111,0x22222222,0x33333333 with instr_adr_o 0..3.
- Consumer ready=0 -> exactly DEPTH=8 words fetched, two bursts, then cyc stays 0. Raising ready drains 8 words in 8 cycles, after which a new burst starts at adr 8.
- Redirect to 0x40 during beat 1 of a burst -> DRAIN shows one cti=111 beat whose data is discarded. The next burst starts at 0x40 and the first valid word is mem[0x40] with instr_adr_o=0x40; no stale word is ever valid.
- Redirect with valid&ready in the same cycle -> FIFO empty next cycle; popped-count excludes flushed entries.
- Redirect to 0x3FFFFFFE -> burst addresses 3FFFFFFE, 3FFFFFFF, 0, 1.
- rst_i pulsed mid-burst -> cyc=stb=0 on the next edge, FIFO empty, refetch starts from RESET_ADR; with WB_FETCH_PERF_EN, counters read 0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone instruction fetch buffer.
//   - Wishbone cycle type identifier (CTI) encodings
//   - Fetch FSM state type
//   - FIFO entry layout: word address plus instruction data
package wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [29:0] adr;
    logic [31:0] dat;
  } fetch_entry_t;

  localparam int unsigned FETCH_ENTRY_W = $bits(fetch_entry_t);

  // CTI to present for a burst beat; only the final beat ends the burst.
  function automatic logic [2:0] burst_cti(input logic last_beat);
    return last_beat ? CTI_EOB : CTI_INCR;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   flush_i        empty the FIFO; takes priority over push and pop
//   push_i/wdata_i write one entry (dropped when full without a same-cycle pop)
//   pop_i/rdata_o  rdata_o is the head entry; pop_i advances it (ignored when empty)
//   count_o        number of entries held, $clog2(DEPTH)+1 bits
//   empty_o/full_o occupancy flags
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i && !rst_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/wb_fetch_buffer.sv
// Wishbone classic-burst instruction prefetcher.
// Fetches sequential 32-bit words in incrementing bursts of BURST_LEN beats into a
// DEPTH-entry FIFO consumed through a valid/ready interface. A redirect flushes the
// FIFO and restarts fetching at a new word address; an interrupted burst is closed
// with one extra cti=111 beat whose data is thrown away.
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   redirect_i/redirect_adr_i flush and restart fetch at a word address
//   instr_o/instr_adr_o       FIFO head word and its word address
//   instr_valid_o/ready_i     head valid; popped when valid & ready
//   wb_*                      Wishbone master (read only, full-word select)
//   perf_words_o/perf_flush_o popped-word and redirect counters, present only when
//                             WB_FETCH_PERF_EN is defined
module wb_fetch_buffer
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned BURST_LEN = 4,
  parameter logic [29:0] RESET_ADR = 30'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        redirect_i,
  input  logic [29:0] redirect_adr_i,
  output logic [31:0] instr_o,
  output logic [29:0] instr_adr_o,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic [29:0] wb_adr_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic [2:0]  wb_cti_o,
  input  logic        wb_ack_i
`ifdef WB_FETCH_PERF_EN
  ,
  output logic [31:0] perf_words_o,
  output logic [15:0] perf_flush_o
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned BW = $clog2(BURST_LEN);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

  fetch_state_t  state_q;
  logic [29:0]   fetch_adr_q;
  logic [29:0]   adr_q;
  logic [2:0]    cti_q;
  logic          req_q;
  logic [BW-1:0] beat_q;

  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_empty;
  logic          fifo_full;
  logic [CW-1:0] fifo_count;
  fetch_entry_t  push_entry;
  fetch_entry_t  head_entry;
  logic [31:0]   inflight;
  logic          space_ok;

  // Beats still owed by the slave for the current burst. Drain beats are discarded,
  // so they need no FIFO space.
  always_comb begin
    inflight = '0;
    if (state_q == BURST) begin
      inflight = 32'(BURST_LEN) - 32'(beat_q);
    end
  end

  // Reserving a whole burst up front means an acked beat can always be pushed.
  assign space_ok = ~fifo_full &&
                    ((32'(fifo_count) + inflight) <= 32'(DEPTH - BURST_LEN));

  // Redirect wins over same-cycle ack data and over a same-cycle pop.
  assign fifo_push      = (state_q == BURST) & wb_ack_i & ~redirect_i;
  assign fifo_pop       = instr_valid_o & instr_ready_i & ~redirect_i;
  assign push_entry.adr = adr_q;
  assign push_entry.dat = wb_dat_i;

  sync_fifo #(
    .WIDTH (FETCH_ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (redirect_i),
    .push_i  (fifo_push),
    .wdata_i (push_entry),
    .pop_i   (fifo_pop),
    .rdata_o (head_entry),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign instr_o       = head_entry.dat;
  assign instr_adr_o   = head_entry.adr;
  assign instr_valid_o = ~fifo_empty;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      fetch_adr_q <= RESET_ADR;
      adr_q       <= '0;
      cti_q       <= CTI_CLASSIC;
      req_q       <= 1'b0;
      beat_q      <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (redirect_i) begin
            fetch_adr_q <= redirect_adr_i;
          end else if (space_ok) begin
            state_q <= BURST;
            req_q   <= 1'b1;
            adr_q   <= fetch_adr_q;
            beat_q  <= '0;
            cti_q   <= burst_cti(LAST_BEAT == '0);
          end
        end

        BURST: begin
          if (redirect_i) begin
            // Close the slave's burst legally; the next beat address keeps the
            // sequence the slave expects.
            fetch_adr_q <= redirect_adr_i;
            state_q     <= DRAIN;
            cti_q       <= CTI_EOB;
            if (wb_ack_i) adr_q <= adr_q + 30'd1;
          end else if (wb_ack_i) begin
            if (beat_q == LAST_BEAT) begin
              state_q     <= IDLE;
              req_q       <= 1'b0;
              cti_q       <= CTI_CLASSIC;
              fetch_adr_q <= adr_q + 30'd1;
            end else begin
              beat_q <= beat_q + BW'(1);
              adr_q  <= adr_q + 30'd1;
              cti_q  <= burst_cti((beat_q + BW'(1)) == LAST_BEAT);
            end
          end
        end

        DRAIN: begin
          if (redirect_i) fetch_adr_q <= redirect_adr_i;
          if (wb_ack_i) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            cti_q   <= CTI_CLASSIC;
          end
        end

        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
          cti_q   <= CTI_CLASSIC;
        end
      endcase
    end
  end

  assign wb_cyc_o = req_q;
  assign wb_stb_o = req_q;
  assign wb_adr_o = adr_q;
  assign wb_cti_o = cti_q;
  assign wb_we_o  = 1'b0;
  assign wb_sel_o = 4'b1111;
  assign wb_dat_o = '0;

`ifdef WB_FETCH_PERF_EN
  logic [31:0] perf_words_q;
  logic [15:0] perf_flush_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_words_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (fifo_pop)   perf_words_q <= perf_words_q + 32'd1;
      if (redirect_i) perf_flush_q <= perf_flush_q + 16'd1;
    end
  end

  assign perf_words_o = perf_words_q;
  assign perf_flush_o = perf_flush_q;
`else
  // Counters absent: pop and redirect strobes feed only the FIFO.
`endif

endmodule

// File: tb/tb_wb_fetch_buffer.sv
// Self-checking bench for wb_fetch_buffer with a behavioural Wishbone RAM slave.
// Expected instruction stream: after reset or a redirect to X the consumer must see
// words X, X+1, ... (30-bit wrap) with data ram_word(adr), whatever the bus timing.
module tb_wb_fetch_buffer;
  import wb_pkg::*;

  localparam int unsigned DEPTH     = 8;
  localparam int unsigned BURST_LEN = 4;
  localparam logic [29:0] RESET_ADR = 30'h0;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        redirect_i;
  logic [29:0] redirect_adr_i;
  logic [31:0] instr_o;
  logic [29:0] instr_adr_o;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic [29:0] wb_adr_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [2:0]  wb_cti_o;
  logic        wb_ack_i = 1'b0;
`ifdef WB_FETCH_PERF_EN
  logic [31:0] perf_words_o;
  logic [15:0] perf_flush_o;
`endif

  always #5 clk = ~clk;

  wb_fetch_buffer #(
    .DEPTH     (DEPTH),
    .BURST_LEN (BURST_LEN),
    .RESET_ADR (RESET_ADR)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .redirect_i     (redirect_i),
    .redirect_adr_i (redirect_adr_i),
    .instr_o        (instr_o),
    .instr_adr_o    (instr_adr_o),
    .instr_valid_o  (instr_valid_o),
    .instr_ready_i  (instr_ready_i),
    .wb_dat_i       (wb_dat_i),
    .wb_dat_o       (wb_dat_o),
    .wb_adr_o       (wb_adr_o),
    .wb_we_o        (wb_we_o),
    .wb_sel_o       (wb_sel_o),
    .wb_cyc_o       (wb_cyc_o),
    .wb_stb_o       (wb_stb_o),
    .wb_cti_o       (wb_cti_o),
    .wb_ack_i       (wb_ack_i)
`ifdef WB_FETCH_PERF_EN
    ,
    .perf_words_o   (perf_words_o),
    .perf_flush_o   (perf_flush_o)
`endif
  );

  typedef struct packed {
    logic [29:0] adr;
    logic [2:0]  cti;
  } bus_ev_t;

  bus_ev_t     bus_q[$];
  logic [29:0] exp_q[$];
  logic [29:0] exp_tail;
  int          n_checks = 0;
  int          n_fail = 0;
  bit          stall_en = 1'b0;
  int          model_pops = 0;
  int          model_redirects = 0;

  function automatic logic [31:0] ram_word(input logic [29:0] a);
    return 32'(a) * 32'h11111111;
  endfunction

  // RAM slave: combinational read data, registered ack, ack drops after an EOB beat.
  assign wb_dat_i = ram_word(wb_adr_o);

  always @(posedge clk) begin
    if (wb_cyc_o && wb_stb_o && !(wb_ack_i && wb_cti_o == CTI_EOB)) begin
      wb_ack_i <= stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    end else begin
      wb_ack_i <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected stream restarts at a new address; the monitor extends it on demand.
  task automatic restart(input logic [29:0] a);
    exp_q.delete();
    exp_tail = a;
    for (int i = 0; i < 32; i++) begin
      exp_q.push_back(exp_tail);
      exp_tail = exp_tail + 30'd1;
    end
  endtask

  // Monitor: sampled on the falling edge, between input updates and DUT edges.
  always @(negedge clk) begin
    if (wb_cyc_o && wb_ack_i && !rst_i) begin
      bus_q.push_back({wb_adr_o, wb_cti_o});
      check("bus_cti_legal", 64'(wb_cti_o == CTI_INCR || wb_cti_o == CTI_EOB), 64'd1);
    end
    if (!rst_i && !redirect_i && instr_valid_o && instr_ready_i) begin
      logic [29:0] e;
      while (exp_q.size() < 16) begin
        exp_q.push_back(exp_tail);
        exp_tail = exp_tail + 30'd1;
      end
      e = exp_q.pop_front();
      check("instr_adr", 64'(instr_adr_o), 64'(e));
      check("instr_dat", 64'(instr_o), 64'(ram_word(e)));
      model_pops++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [29:0] a);
    redirect_i     = 1'b1;
    redirect_adr_i = a;
    restart(a);
    model_redirects++;
    tick();
    redirect_i = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst_i = 1'b1;
    restart(RESET_ADR);
    repeat (n) tick();
    model_pops      = 0;
    model_redirects = 0;
    rst_i = 1'b0;
  endtask

  task automatic wait_bus(input int n, input int budget, input string name);
    int k = 0;
    while (bus_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    check(name, 64'(bus_q.size() >= n), 64'd1);
  endtask

  task automatic check_perf(input string name);
`ifdef WB_FETCH_PERF_EN
    check({name, "_words"}, 64'(perf_words_o), 64'(model_pops));
    check({name, "_flush"}, 64'(perf_flush_o), 64'(16'(model_redirects)));
`else
    if (name.len() == 0) $display("perf counters not built");
`endif
  endtask

  initial begin
    int k;
    int v;
    logic [29:0] a;

    rst_i          = 1'b1;
    redirect_i     = 1'b0;
    redirect_adr_i = '0;
    instr_ready_i  = 1'b1;
    restart(RESET_ADR);
    repeat (3) tick();

    // Reset state
    check("rst_cyc", 64'(wb_cyc_o), 64'd0);
    check("rst_stb", 64'(wb_stb_o), 64'd0);
    check("rst_cti", 64'(wb_cti_o), 64'(CTI_CLASSIC));
    check("rst_valid", 64'(instr_valid_o), 64'd0);
    check("rst_we", 64'(wb_we_o), 64'd0);
    check("rst_sel", 64'(wb_sel_o), 64'hF);
    check("rst_dat_o", 64'(wb_dat_o), 64'd0);
    check_perf("rst_perf");
    rst_i = 1'b0;
    bus_q.delete();

    // First burst after reset: adr 0..3, cti 010,010,010,111
    wait_bus(4, 20, "t1_bus_timeout");
    for (int i = 0; i < 4; i++) begin
      check("t1_adr", 64'(bus_q[i].adr), 64'(i));
      check("t1_cti", 64'(bus_q[i].cti), 64'((i == 3) ? CTI_EOB : CTI_INCR));
    end

    // Stalled consumer: exactly DEPTH words in two bursts, then bus idle
    instr_ready_i = 1'b0;
    do_reset(2);
    bus_q.delete();
    repeat (40) tick();
    check("t2_fetched", 64'(bus_q.size()), 64'(DEPTH));
    check("t2_cyc_idle", 64'(wb_cyc_o), 64'd0);
    check("t2_valid", 64'(instr_valid_o), 64'd1);
    bus_q.delete();
    instr_ready_i = 1'b1;
    v = 0;
    for (int i = 0; i < 8; i++) begin
      if (instr_valid_o) v++;
      tick();
    end
    check("t2_drain_valid_cycles", 64'(v), 64'd8);
    wait_bus(1, 20, "t2_bus_timeout");
    check("t2_next_burst_adr", 64'(bus_q[0].adr), 64'd8);

    // Redirect in IDLE: 3-cycle latency, then wrap across the top of the space
    instr_ready_i = 1'b0;
    repeat (40) tick();
    bus_q.delete();
    do_redirect(30'h3FFFFFFE);
    k = 0;
    while (!instr_valid_o && k < 10) begin
      tick();
      k++;
    end
    check("t3_latency", 64'(k), 64'd3);
    instr_ready_i = 1'b1;
    wait_bus(4, 30, "t3_bus_timeout");
    check("t3_adr0", 64'(bus_q[0].adr), 64'h3FFFFFFE);
    check("t3_adr1", 64'(bus_q[1].adr), 64'h3FFFFFFF);
    check("t3_adr2", 64'(bus_q[2].adr), 64'h0);
    check("t3_adr3", 64'(bus_q[3].adr), 64'h1);

    // Redirect during beat 1: one discarded EOB beat, then refetch at 0x40
    k = 0;
    while (wb_cyc_o && k < 50) begin
      tick();
      k++;
    end
    check("t4_idle_seen", 64'(wb_cyc_o), 64'd0);
    bus_q.delete();
    k = 0;
    while (bus_q.size() < 1 && k < 20) begin
      tick();
      k++;
    end
    do_redirect(30'h40);
    check("t4_no_stale", 64'(instr_valid_o), 64'd0);
    wait_bus(4, 30, "t4_bus_timeout");
    check("t4_drain_cti", 64'(bus_q[2].cti), 64'(CTI_EOB));
    check("t4_restart_adr", 64'(bus_q[3].adr), 64'h40);
    check("t4_restart_cti", 64'(bus_q[3].cti), 64'(CTI_INCR));

    // Redirect together with a pop: FIFO empty next cycle
    k = 0;
    while (!instr_valid_o && k < 20) begin
      tick();
      k++;
    end
    check("t5_valid_before", 64'(instr_valid_o), 64'd1);
    do_redirect(30'h123);
    check("t5_empty_after", 64'(instr_valid_o), 64'd0);
    check_perf("t5_perf");

    // Reset pulsed mid-burst
    k = 0;
    while (!wb_cyc_o && k < 20) begin
      tick();
      k++;
    end
    rst_i = 1'b1;
    restart(RESET_ADR);
    tick();
    model_pops      = 0;
    model_redirects = 0;
    check("t6_cyc", 64'(wb_cyc_o), 64'd0);
    check("t6_stb", 64'(wb_stb_o), 64'd0);
    check("t6_valid", 64'(instr_valid_o), 64'd0);
    check_perf("t6_perf");
    rst_i = 1'b0;
    bus_q.delete();
    wait_bus(1, 20, "t6_bus_timeout");
    check("t6_refetch_adr", 64'(bus_q[0].adr), 64'(RESET_ADR));

    // Random traffic: consumer stalls, slave wait states, redirects, rare resets
    stall_en = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      instr_ready_i = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 999) == 0) begin
        do_reset(1);
      end else if ($urandom_range(0, 39) == 0) begin
        if ($urandom_range(0, 3) == 0) a = 30'h3FFFFFF8 + 30'($urandom_range(0, 7));
        else a = 30'($urandom);
        do_redirect(a);
      end else begin
        tick();
      end
      if (bus_q.size() > 64) bus_q.delete();
    end
    stall_en      = 1'b0;
    instr_ready_i = 1'b1;
    repeat (40) tick();
    check("end_valid_streaming", 64'(wb_we_o | (wb_sel_o != 4'hF)), 64'd0);
    check_perf("end_perf");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
